// File: rtl/calc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : calc_ctrl
// Description : Calculator control FSM. Edge-detects the held key command,
//               sequences entry/accumulator strobes and the multi-cycle ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_ctrl #(
  parameter int MAX_DIGITS  = 8,
  parameter int ALU_TIMEOUT = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] cmd,
  input  logic       alu_done,
  input  logic       alu_ovf,
  output logic       entry_shift,
  output logic [3:0] entry_digit,
  output logic       entry_clear,
  output logic       acc_load,
  output logic       acc_clear,
  output logic       alu_start,
  output logic [1:0] alu_op,
  output logic       result_load,
  output logic       disp_sel,
  output logic [1:0] status
);

  localparam int c_CW = $clog2(MAX_DIGITS + 1);
  localparam int c_TW = $clog2(ALU_TIMEOUT);
  localparam logic [c_CW-1:0] c_MAX_CNT  = c_CW'(MAX_DIGITS);
  localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(ALU_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_EDIT_A = 3'd0,
    S_EDIT_B = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_RESULT = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t          r_state, w_state;
  logic [3:0]      r_cmd_q;
  logic [c_CW-1:0] r_cnt, w_cnt;
  logic [c_TW-1:0] r_tmo, w_tmo;
  logic [1:0]      r_op, w_op, r_pend_op, w_pend_op;
  logic            r_chain, w_chain;
  logic            r_shift_pend, w_shift_pend;
  logic [3:0]      r_pend_digit, w_pend_digit;

  logic            r_entry_shift, w_entry_shift;
  logic [3:0]      r_entry_digit, w_entry_digit;
  logic            r_entry_clear, w_entry_clear;
  logic            r_acc_load, w_acc_load;
  logic            r_acc_clear, w_acc_clear;
  logic            r_alu_start, w_alu_start;
  logic [1:0]      r_alu_op, w_alu_op;
  logic            r_result_load, w_result_load;
  logic            r_disp_sel, w_disp_sel;
  logic [1:0]      r_status, w_status;

  // A held key is seen once: only a change to a non-idle code is an event.
  logic       w_event, w_digit, w_opkey, w_clr, w_eq;
  logic [1:0] w_cmd_op;
  assign w_event  = (cmd != r_cmd_q) && (cmd != 4'hF);
  assign w_digit  = w_event && (cmd <= 4'd9);
  assign w_opkey  = w_event && (cmd >= 4'hA) && (cmd <= 4'hC);
  assign w_clr    = w_event && (cmd == 4'hD);
  assign w_eq     = w_event && (cmd == 4'hE);
  assign w_cmd_op = cmd[1:0] + 2'd2;

  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_tmo         = r_tmo;
    w_op          = r_op;
    w_pend_op     = r_pend_op;
    w_chain       = r_chain;
    w_shift_pend  = r_shift_pend;
    w_pend_digit  = r_pend_digit;
    w_entry_shift = 1'b0;
    w_entry_digit = r_entry_digit;
    w_entry_clear = 1'b0;
    w_acc_load    = 1'b0;
    w_acc_clear   = 1'b0;
    w_alu_start   = 1'b0;
    w_alu_op      = r_alu_op;
    w_result_load = 1'b0;

    if (w_clr) begin
      w_entry_clear = 1'b1;
      w_acc_clear   = 1'b1;
      w_chain       = 1'b0;
      w_cnt         = '0;
      w_tmo         = '0;
      w_shift_pend  = 1'b0;
      w_state       = S_EDIT_A;
    end else begin
      case (r_state)
        S_EDIT_A: begin
          // Digit carried over from RESULT goes in right after its entry_clear.
          if (r_shift_pend) begin
            w_shift_pend  = 1'b0;
            w_entry_shift = 1'b1;
            w_entry_digit = r_pend_digit;
            w_cnt         = r_cnt + 1'b1;
          end else if (w_digit && (r_cnt != c_MAX_CNT)) begin
            w_entry_shift = 1'b1;
            w_entry_digit = cmd;
            w_cnt         = r_cnt + 1'b1;
          end else if (w_opkey) begin
            w_acc_load    = 1'b1;
            w_entry_clear = 1'b1;
            w_op          = w_cmd_op;
            w_cnt         = '0;
            w_state       = S_EDIT_B;
          end
        end
        S_EDIT_B: begin
          if (w_digit && (r_cnt != c_MAX_CNT)) begin
            w_entry_shift = 1'b1;
            w_entry_digit = cmd;
            w_cnt         = r_cnt + 1'b1;
          end else if (w_opkey) begin
            if (r_cnt == '0) begin
              w_op = w_cmd_op;
            end else begin
              w_chain   = 1'b1;
              w_pend_op = w_cmd_op;
              w_state   = S_START;
            end
          end else if (w_eq && (r_cnt != '0)) begin
            w_chain = 1'b0;
            w_state = S_START;
          end
        end
        S_START: begin
          w_alu_start = 1'b1;
          w_alu_op    = r_op;
          w_tmo       = '0;
          w_state     = S_WAIT;
        end
        S_WAIT: begin
          if (alu_done) begin
            if (alu_ovf) begin
              w_state = S_ERROR;
            end else begin
              w_result_load = 1'b1;
              if (r_chain) begin
                w_op          = r_pend_op;
                w_entry_clear = 1'b1;
                w_chain       = 1'b0;
                w_cnt         = '0;
                w_state       = S_EDIT_B;
              end else begin
                w_state = S_RESULT;
              end
            end
          end else if (r_tmo == c_TMO_LAST) begin
            w_state = S_ERROR;
          end else begin
            w_tmo = r_tmo + 1'b1;
          end
        end
        S_RESULT: begin
          if (w_digit) begin
            w_entry_clear = 1'b1;
            w_acc_clear   = 1'b1;
            w_cnt         = '0;
            w_shift_pend  = 1'b1;
            w_pend_digit  = cmd;
            w_state       = S_EDIT_A;
          end else if (w_opkey) begin
            w_op          = w_cmd_op;
            w_entry_clear = 1'b1;
            w_cnt         = '0;
            w_state       = S_EDIT_B;
          end
        end
        default: begin
          w_state = r_state;
        end
      endcase
    end

    case (w_state)
      S_START, S_WAIT: w_status = 2'b01;
      S_RESULT:        w_status = 2'b10;
      S_ERROR:         w_status = 2'b11;
      default:         w_status = 2'b00;
    endcase
    w_disp_sel = (w_state == S_RESULT) || (w_state == S_ERROR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_EDIT_A;
      r_cmd_q       <= 4'hF;
      r_cnt         <= '0;
      r_tmo         <= '0;
      r_op          <= 2'b00;
      r_pend_op     <= 2'b00;
      r_chain       <= 1'b0;
      r_shift_pend  <= 1'b0;
      r_pend_digit  <= 4'd0;
      r_entry_shift <= 1'b0;
      r_entry_digit <= 4'd0;
      r_entry_clear <= 1'b0;
      r_acc_load    <= 1'b0;
      r_acc_clear   <= 1'b0;
      r_alu_start   <= 1'b0;
      r_alu_op      <= 2'b00;
      r_result_load <= 1'b0;
      r_disp_sel    <= 1'b0;
      r_status      <= 2'b00;
    end else begin
      r_state       <= w_state;
      r_cmd_q       <= cmd;
      r_cnt         <= w_cnt;
      r_tmo         <= w_tmo;
      r_op          <= w_op;
      r_pend_op     <= w_pend_op;
      r_chain       <= w_chain;
      r_shift_pend  <= w_shift_pend;
      r_pend_digit  <= w_pend_digit;
      r_entry_shift <= w_entry_shift;
      r_entry_digit <= w_entry_digit;
      r_entry_clear <= w_entry_clear;
      r_acc_load    <= w_acc_load;
      r_acc_clear   <= w_acc_clear;
      r_alu_start   <= w_alu_start;
      r_alu_op      <= w_alu_op;
      r_result_load <= w_result_load;
      r_disp_sel    <= w_disp_sel;
      r_status      <= w_status;
    end
  end

  assign entry_shift = r_entry_shift;
  assign entry_digit = r_entry_digit;
  assign entry_clear = r_entry_clear;
  assign acc_load    = r_acc_load;
  assign acc_clear   = r_acc_clear;
  assign alu_start   = r_alu_start;
  assign alu_op      = r_alu_op;
  assign result_load = r_result_load;
  assign disp_sel    = r_disp_sel;
  assign status      = r_status;

endmodule
`default_nettype wire

// File: tb/tb_calc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_ctrl
// Description : Directed self-checking bench for calc_ctrl with a mock ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_ctrl;

  localparam int c_TIMEOUT = 64;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] cmd;
  logic       alu_done;
  logic       alu_ovf;
  logic       entry_shift;
  logic [3:0] entry_digit;
  logic       entry_clear;
  logic       acc_load;
  logic       acc_clear;
  logic       alu_start;
  logic [1:0] alu_op;
  logic       result_load;
  logic       disp_sel;
  logic [1:0] status;

  int checks = 0;
  int errors = 0;

  // 0 = silent, 1 = answer 3 cycles after alu_start, 3 = fire a single done
  int   mock_mode = 0;
  logic mock_ovf  = 1'b0;
  int   mock_cnt  = -1;

  int         n_shift = 0, n_eclr = 0, n_aload = 0, n_aclr = 0, n_start = 0, n_rload = 0;
  logic [3:0] last_digit = 4'd0;
  logic [1:0] start_op = 2'b00;

  calc_ctrl #(.MAX_DIGITS(8), .ALU_TIMEOUT(c_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .cmd(cmd), .alu_done(alu_done), .alu_ovf(alu_ovf),
    .entry_shift(entry_shift), .entry_digit(entry_digit), .entry_clear(entry_clear),
    .acc_load(acc_load), .acc_clear(acc_clear), .alu_start(alu_start), .alu_op(alu_op),
    .result_load(result_load), .disp_sel(disp_sel), .status(status)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (entry_shift) begin
      n_shift    <= n_shift + 1;
      last_digit <= entry_digit;
    end
    if (entry_clear) n_eclr  <= n_eclr + 1;
    if (acc_load)    n_aload <= n_aload + 1;
    if (acc_clear)   n_aclr  <= n_aclr + 1;
    if (result_load) n_rload <= n_rload + 1;
    if (alu_start) begin
      n_start  <= n_start + 1;
      start_op <= alu_op;
    end
  end

  initial begin
    alu_done = 1'b0;
    alu_ovf  = 1'b0;
    forever begin
      @(negedge clock);
      alu_done = 1'b0;
      alu_ovf  = 1'b0;
      if (mock_mode == 3) begin
        alu_done = 1'b1;
      end else if (mock_mode == 1) begin
        if (mock_cnt > 0) begin
          mock_cnt = mock_cnt - 1;
          if (mock_cnt == 0) begin
            alu_done = 1'b1;
            alu_ovf  = mock_ovf;
            mock_cnt = -1;
          end
        end
        if (alu_start) mock_cnt = 3;
      end else begin
        mock_cnt = -1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] k, input int n);
    cmd = k;
    tick(n);
  endtask

  task automatic do_reset;
    mock_mode = 0;
    mock_ovf  = 1'b0;
    cmd       = 4'hF;
    reset     = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (alu_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    cmd   = 4'hF;
    reset = 1'b1;
    tick(3);
    checks++;
    if ({entry_shift, entry_clear, acc_load, acc_clear, alu_start, result_load} !== 6'b0) begin
      errors++;
      $display("FAIL reset_pulses got=%b want=000000",
               {entry_shift, entry_clear, acc_load, acc_clear, alu_start, result_load});
    end
    checks++;
    if ({status, disp_sel, alu_op} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_status got=%b want=00000", {status, disp_sel, alu_op});
    end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_basic;
    int s0, a0, st0, r0, busy;
    do_reset();
    mock_mode = 1;
    s0 = n_shift;
    press(4'h1, 10);
    checks++;
    if (n_shift - s0 != 1 || last_digit !== 4'd1) begin
      errors++;
      $display("FAIL basic_digit1 shifts=%0d digit=%0d want 1/1", n_shift - s0, last_digit);
    end
    a0 = n_aload;
    press(4'hA, 10);
    checks++;
    if (n_aload - a0 != 1 || n_shift - s0 != 1) begin
      errors++;
      $display("FAIL basic_op acc_load=%0d shifts=%0d want 1/1", n_aload - a0, n_shift - s0);
    end
    press(4'h2, 10);
    checks++;
    if (n_shift - s0 != 2 || last_digit !== 4'd2 || status !== 2'b00) begin
      errors++;
      $display("FAIL basic_digit2 shifts=%0d digit=%0d status=%b want 2/2/00",
               n_shift - s0, last_digit, status);
    end
    st0  = n_start;
    r0   = n_rload;
    busy = 0;
    cmd  = 4'hE;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (status === 2'b01) busy++;
    end
    checks++;
    if (n_start - st0 != 1 || start_op !== 2'b00) begin
      errors++;
      $display("FAIL basic_start starts=%0d op=%b want 1/00", n_start - st0, start_op);
    end
    checks++;
    if (busy != 5) begin
      errors++;
      $display("FAIL basic_busy cycles=%0d want 5", busy);
    end
    checks++;
    if (n_rload - r0 != 1 || status !== 2'b10 || disp_sel !== 1'b1) begin
      errors++;
      $display("FAIL basic_result rload=%0d status=%b disp=%b want 1/10/1",
               n_rload - r0, status, disp_sel);
    end
  endtask

  task automatic test_digits;
    int s0;
    do_reset();
    s0 = n_shift;
    press(4'h5, 50);
    press(4'hF, 2);
    press(4'h5, 3);
    checks++;
    if (n_shift - s0 != 2) begin
      errors++;
      $display("FAIL hold_repeat shifts=%0d want 2", n_shift - s0);
    end
    do_reset();
    s0 = n_shift;
    for (int d = 1; d <= 9; d++) press(4'(d), 2);
    checks++;
    if (n_shift - s0 != 8 || last_digit !== 4'd8) begin
      errors++;
      $display("FAIL max_digits shifts=%0d last=%0d want 8/8", n_shift - s0, last_digit);
    end
  endtask

  task automatic test_chain;
    int e0, r0, st0;
    do_reset();
    mock_mode = 1;
    press(4'h3, 10);
    press(4'hC, 10);
    press(4'h4, 10);
    e0 = n_eclr;
    r0 = n_rload;
    press(4'hA, 10);
    checks++;
    if (start_op !== 2'b10) begin
      errors++;
      $display("FAIL chain_mul_op got=%b want=10", start_op);
    end
    checks++;
    if (n_rload - r0 != 1 || n_eclr - e0 != 1 || status !== 2'b00) begin
      errors++;
      $display("FAIL chain_after rload=%0d eclr=%0d status=%b want 1/1/00",
               n_rload - r0, n_eclr - e0, status);
    end
    press(4'h1, 10);
    st0 = n_start;
    press(4'hE, 10);
    checks++;
    if (n_start - st0 != 1 || start_op !== 2'b00 || status !== 2'b10) begin
      errors++;
      $display("FAIL chain_pending_op starts=%0d op=%b status=%b want 1/00/10",
               n_start - st0, start_op, status);
    end
  endtask

  task automatic test_overflow;
    int s0, st0, e0, c0, r0;
    do_reset();
    mock_mode = 1;
    mock_ovf  = 1'b1;
    press(4'h7, 5);
    press(4'hA, 5);
    press(4'h8, 5);
    r0 = n_rload;
    press(4'hE, 10);
    checks++;
    if (status !== 2'b11 || disp_sel !== 1'b1 || n_rload != r0) begin
      errors++;
      $display("FAIL ovf_error status=%b disp=%b rload=%0d want 11/1/0",
               status, disp_sel, n_rload - r0);
    end
    s0  = n_shift;
    st0 = n_start;
    press(4'h5, 5);
    press(4'hE, 5);
    checks++;
    if (n_shift != s0 || n_start != st0 || status !== 2'b11) begin
      errors++;
      $display("FAIL ovf_ignore shifts=%0d starts=%0d status=%b want 0/0/11",
               n_shift - s0, n_start - st0, status);
    end
    e0 = n_eclr;
    c0 = n_aclr;
    press(4'hD, 3);
    checks++;
    if (n_eclr - e0 != 1 || n_aclr - c0 != 1 || status !== 2'b00 || disp_sel !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear eclr=%0d aclr=%0d status=%b disp=%b want 1/1/00/0",
               n_eclr - e0, n_aclr - c0, status, disp_sel);
    end
    mock_ovf = 1'b0;
  endtask

  task automatic test_timeout;
    bit found;
    int cycles, r0, c0;
    do_reset();
    press(4'h1, 3);
    press(4'hA, 3);
    press(4'h2, 3);
    cmd = 4'hE;
    wait_start(found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL tmo_start got=0 want=alu_start within 10 cycles");
    end
    cycles = 0;
    while (status !== 2'b11 && cycles < 200) begin
      tick(1);
      cycles++;
    end
    checks++;
    if (cycles != c_TIMEOUT) begin
      errors++;
      $display("FAIL tmo_cycles got=%0d want=%0d", cycles, c_TIMEOUT);
    end
    press(4'hD, 3);

    do_reset();
    press(4'h1, 3);
    press(4'hA, 3);
    press(4'h2, 3);
    cmd = 4'hE;
    wait_start(found);
    tick(5);
    checks++;
    if (!found || status !== 2'b01) begin
      errors++;
      $display("FAIL wait_busy found=%0d status=%b want 1/01", found, status);
    end
    r0 = n_rload;
    c0 = n_aclr;
    press(4'hD, 3);
    checks++;
    if (status !== 2'b00 || n_aclr - c0 != 1) begin
      errors++;
      $display("FAIL wait_clear status=%b aclr=%0d want 00/1", status, n_aclr - c0);
    end
    mock_mode = 3;
    tick(1);
    mock_mode = 0;
    tick(4);
    checks++;
    if (n_rload != r0 || status !== 2'b00) begin
      errors++;
      $display("FAIL late_done rload=%0d status=%b want 0/00", n_rload - r0, status);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    press(4'h3, 3);
    press(4'hC, 3);
    press(4'h4, 3);
    press(4'hE, 4);
    checks++;
    if (status !== 2'b01 || alu_op !== 2'b10) begin
      errors++;
      $display("FAIL rst_wait_pre status=%b op=%b want 01/10", status, alu_op);
    end
    reset = 1'b1;
    tick(1);
    checks++;
    if ({status, disp_sel, alu_op, entry_shift, entry_clear, acc_load, acc_clear,
         alu_start, result_load} !== 11'b0) begin
      errors++;
      $display("FAIL rst_wait got=%b want=0", {status, disp_sel, alu_op});
    end
    reset = 1'b0;
    cmd   = 4'hF;
    tick(2);
    mock_mode = 1;
    press(4'h1, 3);
    press(4'hA, 3);
    press(4'h2, 3);
    press(4'hE, 10);
    checks++;
    if (status !== 2'b10) begin
      errors++;
      $display("FAIL rst_result_pre status=%b want 10", status);
    end
    reset = 1'b1;
    tick(1);
    checks++;
    if ({status, disp_sel, entry_shift, entry_clear, acc_load, acc_clear,
         alu_start, result_load} !== 9'b0) begin
      errors++;
      $display("FAIL rst_result status=%b disp=%b", status, disp_sel);
    end
    reset     = 1'b0;
    mock_mode = 0;
    tick(2);
  endtask

  initial begin
    reset = 1'b1;
    cmd   = 4'hF;
    test_reset();
    test_basic();
    test_digits();
    test_chain();
    test_overflow();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
